// File: rtl/abs_diff_pkg.sv
// Shared types and constants for the multi-channel ECG abs-difference stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package abs_diff_pkg;

    localparam int DEF_DATA_WIDTH = 11;

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
    // One extra bit so sample - MA can never wrap.
    typedef logic signed [DEF_DATA_WIDTH:0]   diff_t;

    // Largest positive value representable in a dw-bit signed result.
    function automatic int SAT_MAX(input int dw);
        return (2 ** (dw - 1)) - 1;
    endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// One channel: |sample - MA| with saturation, valid, sticky sat flag, optional peak hold.
// Latency: PIPE_STAGES i_ce-cycles (1: single register stage, 2: diff reg then abs/sat reg).
// Backpressure: none; i_ce=0 freezes the pipe. Optional peak hold under ABS_DIFF_PEAK_HOLD_EN.
// Ports: i_sample/i_ma/i_ma_valid in; o_abs_diff/o_valid out, o_valid_nxt (next output valid,
// for the bank-level all-valid register), o_sat sticky flag, i_peak_clr/o_peak when enabled.
module abs_diff_lane
    import abs_diff_pkg::*;
#(
    parameter int DW          = DEF_DATA_WIDTH,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic signed [DW-1:0] i_sample,
    input  logic signed [DW-1:0] i_ma,
    input  logic                 i_ma_valid,
    input  logic                 i_sat_clr,
`ifdef ABS_DIFF_PEAK_HOLD_EN
    input  logic                 i_peak_clr,
    output logic [DW-1:0]        o_peak,
`endif
    output logic [DW-1:0]        o_abs_diff,
    output logic                 o_valid,
    output logic                 o_valid_nxt,
    output logic                 o_sat
);

    localparam logic [DW:0] SAT_LIM = (DW+1)'(SAT_MAX(DW));

    logic signed [DW:0] diff_c;
    logic signed [DW:0] diff_s;
    logic               vld_s;
    logic [DW:0]        abs_c;
    logic               sat_c;
    logic [DW-1:0]      res_c;

    // Sign-extend both operands first so the subtraction cannot overflow.
    assign diff_c = {i_sample[DW-1], i_sample} - {i_ma[DW-1], i_ma};

    if (PIPE_STAGES == 2) begin : g_two_stage
        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                diff_s <= '0;
                vld_s  <= 1'b0;
            end else if (i_ce) begin
                diff_s <= diff_c;
                vld_s  <= i_ma_valid;
            end
        end
    end else begin : g_one_stage
        assign diff_s = diff_c;
        assign vld_s  = i_ma_valid;
    end

    // |diff| fits DW+1 unsigned bits: the most negative diff is -(2^DW - 1).
    assign abs_c = diff_s[DW] ? $unsigned(-diff_s) : $unsigned(diff_s);
    assign sat_c = vld_s && (abs_c > SAT_LIM);
    assign res_c = !vld_s ? '0 : (sat_c ? SAT_LIM[DW-1:0] : abs_c[DW-1:0]);

    assign o_valid_nxt = vld_s;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_abs_diff <= '0;
            o_valid    <= 1'b0;
        end else if (i_ce) begin
            o_abs_diff <= res_c;
            o_valid    <= vld_s;
        end
    end

    // Set only when a saturated result is actually registered; set beats clear.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_sat <= 1'b0;
        end else if (i_ce && sat_c) begin
            o_sat <= 1'b1;
        end else if (i_sat_clr) begin
            o_sat <= 1'b0;
        end
    end

`ifdef ABS_DIFF_PEAK_HOLD_EN
    // Tracks the registered output; a clear restarts from the current result if valid.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_peak <= '0;
        end else if (i_peak_clr) begin
            o_peak <= o_valid ? o_abs_diff : '0;
        end else if (o_valid && (o_abs_diff > o_peak)) begin
            o_peak <= o_abs_diff;
        end
    end
`endif

endmodule

// File: rtl/abs_diff_bank.sv
// Multi-channel |ECG sample - MA| bank with saturation, sticky flags and aligned sample copy.
// Latency: PIPE_STAGES i_ce-cycles for results, valids, o_all_valid and o_ecg_sample.
// Backpressure: none; i_ce=0 freezes every pipeline register. Macro: ABS_DIFF_PEAK_HOLD_EN.
// Ports: i_ecg_sample, i_ma (ch k at [k*DW +: DW]), i_ma_valid, i_sat_clr in;
// o_ecg_sample, o_abs_diff, o_abs_diff_valid, o_all_valid, o_sat out; i_peak_clr/o_peak optional.
module abs_diff_bank
    import abs_diff_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_CH      = 2,
    parameter int PIPE_STAGES = 2
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_ce,
    input  logic signed [DATA_WIDTH-1:0]   i_ecg_sample,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_ma,
    input  logic [NUM_CH-1:0]              i_ma_valid,
    input  logic                           i_sat_clr,
`ifdef ABS_DIFF_PEAK_HOLD_EN
    input  logic                           i_peak_clr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_peak,
`endif
    output logic signed [DATA_WIDTH-1:0]   o_ecg_sample,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_abs_diff,
    output logic [NUM_CH-1:0]              o_abs_diff_valid,
    output logic                           o_all_valid,
    output logic [NUM_CH-1:0]              o_sat
);

    logic [NUM_CH-1:0]            valid_nxt;
    logic signed [DATA_WIDTH-1:0] ecg_pipe [PIPE_STAGES];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        abs_diff_lane #(
            .DW          (DATA_WIDTH),
            .PIPE_STAGES (PIPE_STAGES)
        ) u_lane (
            .i_clk       (i_clk),
            .i_nrst      (i_nrst),
            .i_ce        (i_ce),
            .i_sample    (i_ecg_sample),
            .i_ma        (i_ma[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_ma_valid  (i_ma_valid[k]),
            .i_sat_clr   (i_sat_clr),
`ifdef ABS_DIFF_PEAK_HOLD_EN
            .i_peak_clr  (i_peak_clr),
            .o_peak      (o_peak[k*DATA_WIDTH +: DATA_WIDTH]),
`endif
            .o_abs_diff  (o_abs_diff[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid     (o_abs_diff_valid[k]),
            .o_valid_nxt (valid_nxt[k]),
            .o_sat       (o_sat[k])
        );
    end

    // Sample delay line has the same depth as the lanes so it stays aligned.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < PIPE_STAGES; i++) ecg_pipe[i] <= '0;
        end else if (i_ce) begin
            ecg_pipe[0] <= i_ecg_sample;
            for (int i = 1; i < PIPE_STAGES; i++) ecg_pipe[i] <= ecg_pipe[i-1];
        end
    end

    assign o_ecg_sample = ecg_pipe[PIPE_STAGES-1];

    // Registered from the lanes' next-state valids so it lands with them.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_all_valid <= 1'b0;
        end else if (i_ce) begin
            o_all_valid <= &valid_nxt;
        end
    end

endmodule
